// File: rtl/conv_3_3.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : conv_3_3
//  Description : 3x3 convolution multiply-accumulate. Multiplies a 9-element
//                patch by a 9-element kernel element-wise and sums the
//                products. Three register stages, one result per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_3_3 #(
  parameter int DATA_W = 16,  // width of each patch/kernel element
  parameter int OUT_W  = 64,  // RESULT width, at least 2*DATA_W+4
  parameter int SIGNED = 0    // 0: unsigned elements, 1: two's complement
) (
  input  logic                CLK,
  input  logic                rst_n,   // active-high async reset despite the name
  input  logic [9*DATA_W-1:0] PATCH,
  input  logic [9*DATA_W-1:0] KERNEL,
  output logic [OUT_W-1:0]    RESULT
);

  localparam int c_prod_w = 2 * DATA_W;      // exact product width
  localparam int c_sum_w  = 2 * DATA_W + 4;  // exact width of a sum of 9 products
  localparam bit c_sgn    = (SIGNED != 0);

  logic [c_prod_w-1:0] prod_d [9];
  logic [c_prod_w-1:0] prod_q [9];
  logic [c_sum_w-1:0]  row_d  [3];
  logic [c_sum_w-1:0]  row_q  [3];
  logic [c_sum_w-1:0]  result_d;
  logic [c_sum_w-1:0]  result_q;

  // Stage 1 products: operands are widened to the product width (sign- or
  // zero-extended) so the low c_prod_w bits of the product are exact either way.
  always_comb begin
    logic [c_prod_w-1:0] w_a;
    logic [c_prod_w-1:0] w_b;
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < 9; i++) begin
      w_a = {{DATA_W{c_sgn & PATCH[DATA_W*i + DATA_W-1]}},  PATCH[DATA_W*i +: DATA_W]};
      w_b = {{DATA_W{c_sgn & KERNEL[DATA_W*i + DATA_W-1]}}, KERNEL[DATA_W*i +: DATA_W]};
      prod_d[i] = w_a * w_b;
    end
  end

  // Stage 2 row sums: each row adds three products extended to the sum width.
  always_comb begin
    logic [c_sum_w-1:0] w_e [9];
    for (int i = 0; i < 9; i++) begin
      w_e[i] = {{4{c_sgn & prod_q[i][c_prod_w-1]}}, prod_q[i]};
    end
    for (int r = 0; r < 3; r++) begin
      row_d[r] = w_e[3*r] + w_e[3*r+1] + w_e[3*r+2];
    end
  end

  // Stage 3 final sum of the three row sums; cannot overflow the sum width.
  always_comb begin
    result_d = row_q[0] + row_q[1] + row_q[2];
  end

  // Pipeline registers; reset flushes every stage immediately.
  always_ff @(posedge CLK or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int r = 0; r < 3; r++) row_q[r]  <= '0;
      result_q <= '0;
    end else begin
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      for (int r = 0; r < 3; r++) row_q[r]  <= row_d[r];
      result_q <= result_d;
    end
  end

  // Output extension is pure wiring from the final register.
  generate
    if (OUT_W > c_sum_w) begin : g_ext
      assign RESULT = {{(OUT_W - c_sum_w){c_sgn & result_q[c_sum_w-1]}}, result_q};
    end else begin : g_noext
      assign RESULT = result_q[OUT_W-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_conv_3_3.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_conv_3_3
//  Description : Self-checking bench for conv_3_3. An unsigned and a signed
//                instance share stimulus; expected results go to a queue
//                tagged with the edge after which they must appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_3_3;

  localparam int DW = 16;
  localparam int OW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [9*DW-1:0] patch  = '0;
  logic [9*DW-1:0] kernel = '0;
  logic [OW-1:0]   res_u;
  logic [OW-1:0]   res_s;

  int errors   = 0;
  int checks   = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [9*DW-1:0] p;
    logic [9*DW-1:0] k;
    logic [OW-1:0]   eu;
    logic [OW-1:0]   es;
  } vec_t;

  typedef struct {
    int            due;
    logic [OW-1:0] eu;
    logic [OW-1:0] es;
  } sb_t;

  sb_t  sb [$];
  sb_t  mon_e;
  vec_t tbl [8];

  conv_3_3 #(.DATA_W(DW), .OUT_W(OW), .SIGNED(0)) u_dut_u (
    .CLK(clk), .rst_n(rst), .PATCH(patch), .KERNEL(kernel), .RESULT(res_u)
  );

  conv_3_3 #(.DATA_W(DW), .OUT_W(OW), .SIGNED(1)) u_dut_s (
    .CLK(clk), .rst_n(rst), .PATCH(patch), .KERNEL(kernel), .RESULT(res_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [9*DW-1:0] rep(input logic [DW-1:0] v);
    logic [9*DW-1:0] r;
    for (int i = 0; i < 9; i++) r[DW*i +: DW] = v;
    return r;
  endfunction

  function automatic logic [9*DW-1:0] ramp(input int start);
    logic [9*DW-1:0] r;
    for (int i = 0; i < 9; i++) r[DW*i +: DW] = DW'(start + i);
    return r;
  endfunction

  // Independent reference: plain 64-bit integer dot product.
  function automatic logic [OW-1:0] model(input logic [9*DW-1:0] p,
                                          input logic [9*DW-1:0] k,
                                          input bit sgn);
    longint acc = 0;
    logic [DW-1:0] a, b;
    for (int i = 0; i < 9; i++) begin
      a = p[DW*i +: DW];
      b = k[DW*i +: DW];
      if (sgn) acc += longint'($signed(a)) * longint'($signed(b));
      else     acc += longint'({48'd0, a}) * longint'({48'd0, b});
    end
    return OW'(acc);
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare both instances when an entry falls due.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (sb[0].due == edge_cnt) begin
        mon_e = sb.pop_front();
        check("sb_unsigned", res_u, mon_e.eu);
        check("sb_signed",   res_s, mon_e.es);
      end else if (sb[0].due < edge_cnt) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL sb_missed: entry due at edge %0d still queued at edge %0d",
                 mon_e.due, edge_cnt);
      end
    end
  end

  // Apply one vector for exactly one sampling edge and queue its result.
  task automatic drive(input logic [9*DW-1:0] p, input logic [9*DW-1:0] k,
                       input logic [OW-1:0] eu, input logic [OW-1:0] es);
    sb_t e;
    @(posedge clk);
    #1;
    patch  = p;
    kernel = k;
    e.due = edge_cnt + 3;
    e.eu  = eu;
    e.es  = es;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
  endtask

  task automatic rand_vec(output logic [9*DW-1:0] p, output logic [9*DW-1:0] k);
    for (int i = 0; i < 9; i++) begin
      p[DW*i +: DW] = DW'($urandom);
      k[DW*i +: DW] = DW'($urandom);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [9*DW-1:0] p, k;

    // Vector table; element i lives at [DW*i +: DW].
    tbl[0] = '{ramp(0), ramp(9), 64'd528, 64'd528};
    tbl[1] = '{ramp(1), ramp(9), 64'd645, 64'd645};
    tbl[2] = '{rep(16'hFFFF), rep(16'hFFFF), 64'h0000_0008_FFEE_0009, 64'd9};
    tbl[3] = '{rep(16'hFFFF), rep(16'h0002), 64'd1179630, 64'hFFFF_FFFF_FFFF_FFEE};
    tbl[4] = '{rep(16'h8000), rep(16'h8000), 64'd9663676416, 64'd9663676416};
    tbl[5] = '{rep(16'h7FFF), rep(16'h8000), 64'd9663381504, 64'hFFFF_FFFD_C004_8000};
    tbl[6] = '{rep(16'h0000), rep(16'h0000), 64'd0, 64'd0};
    p = '0; k = '0;
    p[DW*0 +: DW] = 16'd2; k[DW*0 +: DW] = 16'd100;
    p[DW*4 +: DW] = 16'd1; k[DW*4 +: DW] = 16'd1000;
    p[DW*8 +: DW] = 16'd3; k[DW*8 +: DW] = 16'd5;
    tbl[7] = '{p, k, 64'd1215, 64'd1215};

    // Reset held: output stays zero while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rand_vec(p, k);
      patch = p; kernel = k;
      @(negedge clk);
      check("rst_hold_u", res_u, '0);
      check("rst_hold_s", res_s, '0);
    end

    // Release mid-cycle; first result lands on the third edge.
    @(posedge clk); #1;
    patch = ramp(0); kernel = ramp(9);
    #1 rst = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk);
      @(negedge clk);
      check("release_u", res_u, (j < 3) ? 64'd0 : 64'd528);
      check("release_s", res_s, (j < 3) ? 64'd0 : 64'd528);
    end

    // Single-edge increment of every patch element.
    drive(ramp(0), ramp(9), 64'd528, 64'd528);
    drive(ramp(1), ramp(9), 64'd645, 64'd645);
    drive(ramp(0), ramp(9), 64'd528, 64'd528);
    drain();

    // Table vectors back to back, one per edge.
    for (int i = 0; i < 8; i++) drive(tbl[i].p, tbl[i].k, tbl[i].eu, tbl[i].es);
    drain();

    // Random back-to-back stream against the integer model.
    for (int i = 0; i < 24; i++) begin
      rand_vec(p, k);
      drive(p, k, model(p, k, 1'b0), model(p, k, 1'b1));
    end
    drain();

    // Mid-stream reset: in-flight data must vanish without a clock edge.
    drive(tbl[2].p, tbl[2].k, tbl[2].eu, tbl[2].es);
    drive(tbl[4].p, tbl[4].k, tbl[4].eu, tbl[4].es);
    drive(tbl[5].p, tbl[5].k, tbl[5].eu, tbl[5].es);
    @(posedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    check("async_rst_u", res_u, '0);
    check("async_rst_s", res_s, '0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("flush_hold_u", res_u, '0);
      check("flush_hold_s", res_s, '0);
    end

    // Release again: nothing from before reset may reappear.
    @(posedge clk); #1;
    patch = tbl[7].p; kernel = tbl[7].k;
    #1 rst = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk);
      @(negedge clk);
      check("rerelease_u", res_u, (j < 3) ? 64'd0 : tbl[7].eu);
      check("rerelease_s", res_s, (j < 3) ? 64'd0 : tbl[7].es);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
